// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader state codes and data width.
package loader_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_RUN   = 2'd2,
    S_STEP  = 2'd3
  } state_e;

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-DIV counter that emits a one-cycle tick on the cycle it wraps.
module rate_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Front-panel program loader: writes switch bytes into program RAM, then
// releases the CPU in free-run or single-step mode.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int RUN_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_pulse,
  input  logic              run_pulse,
  input  logic              step_pulse,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_full,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [1:0]        mode
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                full_q, full_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                cpu_en_q, cpu_en_d;
  logic                div_clr, div_en, div_tick;

  // Divider sits at zero outside RUN, so every RUN entry starts a fresh period.
  assign div_en  = (state_q == S_RUN);
  assign div_clr = !div_en;

  rate_divider #(.DIV(RUN_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (div_tick)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    full_d    = full_q;
    cpu_rst_d = cpu_rst_q;
    cpu_en_d  = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (load_pulse) begin
          wdata_d = sw_data;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end else if (run_pulse) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
        end else if (step_pulse) begin
          state_d   = S_STEP;
          cpu_rst_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (we_q && mem_ready) begin
          we_d    = 1'b0;
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
          if (addr_q == ADDR_LAST) full_d = 1'b1;
        end
      end
      S_RUN: begin
        if (load_pulse) begin
          state_d   = S_LOAD;
          cpu_rst_d = 1'b1;
          addr_d    = '0;
          full_d    = 1'b0;
        end else if (run_pulse || step_pulse) begin
          state_d = S_STEP;
        end else begin
          cpu_en_d = div_tick;
        end
      end
      S_STEP: begin
        if (load_pulse) begin
          state_d   = S_LOAD;
          cpu_rst_d = 1'b1;
          addr_d    = '0;
          full_d    = 1'b0;
        end else if (run_pulse) begin
          state_d = S_RUN;
        end else begin
          cpu_en_d = step_pulse;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      full_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      full_q    <= full_d;
      cpu_rst_q <= cpu_rst_d;
      cpu_en_q  <= cpu_en_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_full  = full_q;
  assign cpu_rst   = cpu_rst_q;
  assign cpu_en    = cpu_en_q;
  assign mode      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized + directed bench for program_loader against a cycle-level reference
// model that tracks time-in-RUN and an expected program memory image.
module tb_program_loader;

  localparam int ADDR_W  = 2;
  localparam int RUN_DIV = 4;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_pulse = 1'b0;
  logic              run_pulse  = 1'b0;
  logic              step_pulse = 1'b0;
  logic [7:0]        sw_data    = 8'h00;
  logic              mem_ready  = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_full;
  logic              cpu_rst;
  logic              cpu_en;
  logic [1:0]        mode;

  program_loader #(.ADDR_W(ADDR_W), .RUN_DIV(RUN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_pulse (load_pulse),
    .run_pulse  (run_pulse),
    .step_pulse (step_pulse),
    .sw_data    (sw_data),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_full   (mem_full),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0=LOAD 1=WRITE 2=RUN 3=STEP
  int         m_mode, m_addr, m_t;
  bit         m_full, m_we, m_en;
  logic [7:0] m_wdata;
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] obs_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_t = 0;
    m_full = 0; m_we = 0; m_en = 0; m_wdata = 8'h00;
  endtask

  task automatic model_step(input bit l, input bit r, input bit s,
                            input logic [7:0] sw, input bit rdy);
    m_en = 0;
    case (m_mode)
      0: begin
        if (l) begin m_we = 1; m_wdata = sw; m_mode = 1; end
        else if (r) begin m_mode = 2; m_t = 0; end
        else if (s) m_mode = 3;
      end
      1: begin
        if (m_we && rdy) begin
          exp_mem[m_addr] = m_wdata;
          m_we = 0;
          if (m_addr == DEPTH - 1) m_full = 1;
          m_addr = (m_addr + 1) % DEPTH;
          m_mode = 0;
        end
      end
      default: begin
        if (l) begin m_mode = 0; m_addr = 0; m_full = 0; end
        else if (m_mode == 2 && (r || s)) m_mode = 3;
        else if (m_mode == 3 && r) begin m_mode = 2; m_t = 0; end
        else if (m_mode == 3) m_en = s;
        else begin
          m_t++;
          m_en = (m_t % RUN_DIV == 0);
        end
      end
    endcase
  endtask

  task automatic check_all();
    check("mode",      mode,      m_mode);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("mem_we",    mem_we,    m_we);
    check("mem_full",  mem_full,  m_full);
    check("cpu_rst",   cpu_rst,   (m_mode < 2));
    check("cpu_en",    cpu_en,    m_en);
  endtask

  task automatic cyc(input bit l, input bit r, input bit s,
                     input logic [7:0] sw, input bit rdy);
    @(negedge clk);
    load_pulse = l; run_pulse = r; step_pulse = s; sw_data = sw; mem_ready = rdy;
    #1;
    if (mem_we && mem_ready) begin
      obs_mem[mem_addr] = mem_wdata;
      $display("write addr=%0d data=%02h", mem_addr, mem_wdata);
    end
    @(posedge clk);
    model_step(l, r, s, sw, rdy);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_pulse = 0; run_pulse = 0; step_pulse = 0; mem_ready = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 8'h00;
      obs_mem[i] = 8'h00;
    end
    model_reset();

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single write with memory immediately ready
    cyc(1, 0, 0, 8'hA5, 1);
    cyc(0, 0, 0, 8'h00, 1);

    // Stalled write: extra pulses during the wait must be ignored
    cyc(1, 0, 0, 8'h3C, 0);
    cyc(1, 0, 0, 8'hFF, 0);
    cyc(0, 1, 0, 8'hEE, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    idle(2, 1);

    // Asynchronous reset while a write is pending
    cyc(1, 0, 0, 8'h77, 0);
    do_reset();

    // Fill memory and wrap the address
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, 0, 0, 8'(i), 1);
      cyc(0, 0, 0, 8'h00, 1);
    end

    // Free-run, pause, single step, return to LOAD
    cyc(0, 1, 0, 8'h00, 0);
    idle(13, 0);
    cyc(0, 1, 0, 8'h00, 0);
    idle(3, 0);
    cyc(0, 0, 1, 8'h00, 0);
    idle(3, 0);
    cyc(1, 0, 0, 8'h99, 0);
    idle(2, 0);

    // Simultaneous pulses in STEP: load wins
    cyc(0, 0, 1, 8'h00, 0);
    idle(1, 0);
    cyc(1, 1, 1, 8'h42, 1);
    idle(3, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 5) == 0), 8'($urandom), $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < DEPTH; i++) check("mem_image", obs_mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Consumes the one-cycle press pulses produced by the switch debouncers (load/run/step buttons) plus the 8 data switches.
- Writes switch bytes sequentially into program memory, then releases the 8-bit processor in free-run or single-step mode.
- Sits between the debouncer bank and the processor core / program RAM write port.

Parameters:
- ADDR_W, 4, program memory address width (2^ADDR_W bytes).
- RUN_DIV, 50_000_000, clk cycles between cpu_en pulses in RUN mode (2 Hz at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- load_pulse  input  1  one-cycle debounced press: write switch byte, or return to LOAD
- run_pulse  input  1  one-cycle debounced press: start or pause free-run
- step_pulse  input  1  one-cycle debounced press: single-step
- sw_data  input  8  data switches
- mem_ready  input  1  memory accepts a write this cycle
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- mem_we  output  1  write request, held until accepted
- mem_full  output  1  sticky; set when the address wraps past the last byte
- cpu_rst  output  1  holds the processor in reset
- cpu_en  output  1  processor clock enable
- mode  output  2  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state = LOAD; mem_addr = 0; mem_wdata = 0; mem_we = 0; mem_full = 0; cpu_rst = 1; cpu_en = 0; divider = 0. All outputs are registered.
- States: LOAD = 0, WRITE = 1, RUN = 2, STEP = 3. mode equals the state code.
- Pulse priority when several pulses arrive in the same cycle: load > run > step. Lower-priority pulses in that cycle are dropped.
- LOAD:
  - cpu_rst = 1, cpu_en = 0.
  - load_pulse: mem_wdata <= sw_data; mem_we <= 1; go to WRITE. mem_we is high in the cycle after the pulse.
  - run_pulse: go to RUN. step_pulse: go to STEP.
- WRITE:
  - mem_we and mem_wdata are held stable until the edge where mem_we & mem_ready = 1.
  - On that edge: mem_we <= 0; mem_addr <= mem_addr + 1 (mod 2^ADDR_W); return to LOAD.
  - If mem_addr was 2^ADDR_W - 1, the address wraps to 0 and mem_full <= 1.
  - All pulses are ignored in WRITE (no queuing).
  - mem_ready asserted while mem_we = 0 has no effect.
- RUN:
  - cpu_rst = 0.
  - The divider is cleared on entry. cpu_en is a one-cycle pulse every RUN_DIV cycles; the first pulse comes RUN_DIV cycles after entry.
  - run_pulse: go to STEP (pause). step_pulse: go to STEP, no step executed.
  - load_pulse: go to LOAD with cpu_rst <= 1, mem_addr <= 0, mem_full <= 0. The byte is NOT written.
- STEP:
  - cpu_rst = 0.
  - step_pulse: cpu_en = 1 for exactly one cycle, in the cycle after the pulse.
  - run_pulse: go to RUN.
  - load_pulse: as in RUN.
- Divider: width $clog2(RUN_DIV). It counts only in RUN. It wraps at RUN_DIV - 1, and cpu_en fires on that wrap.
- cpu_en is never high while cpu_rst is high.
- Reset mid-write: mem_we drops immediately (asynchronous). The partial write is the memory's concern; the address returns to 0.

Decomposition:
- Package loader_pkg:
  - State localparams S_LOAD, S_WRITE, S_RUN, S_STEP (2-bit).
  - DATA_W = 8.
- Sub-module rate_divider (params DIV; ports clk, rst, clr, en, tick):
  - Also reusable for display multiplexing.
- FSM, address counter and write handshake stay in program_loader.

Test Plan (bench uses ADDR_W = 2, RUN_DIV = 4):
- Reset -> mode = 0, cpu_rst = 1, mem_we = 0, mem_addr = 0, cpu_en = 0; check all outputs while rst is held.
- sw_data = 8'hA5, load_pulse, mem_ready = 1 -> mem_we high one cycle later with mem_wdata = A5, addr 0; the next cycle addr = 1, mem_we = 0, mode = 0.
- mem_ready low for 3 cycles with a load_pulse and run_pulse during the wait -> mem_we and data held 3 cycles; extra pulses ignored; exactly one write, to the original address.
- Four loads of 01, 02, 03, 04 -> addresses 0..3 written; addr wraps to 0; mem_full = 1.
- run_pulse -> cpu_rst = 0; cpu_en pulses at cycles 4, 8, 12 after entry. Then run_pulse -> STEP: no cpu_en until step_pulse, then exactly one cpu_en cycle. load_pulse -> cpu_rst = 1, addr = 0, mem_full = 0.
- Same-cycle load_pulse + run_pulse + step_pulse in STEP -> LOAD taken; no cpu_en; no write.
